// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, direction and priority codes.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

    // Index width for an N-entry port vector; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side port bundle plus the single memory-side bus of the arbiter.
interface memory_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]            in_PortRequest;
    logic [NUM_PORTS-1:0]            in_PortRW;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] in_PortAddress;
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_PortWriteData;
    logic [NUM_PORTS-1:0]            out_PortWait;
    logic [DATA_WIDTH-1:0]           out_PortReadData;
    logic                            out_MemoryRequest;
    logic                            out_MemoryRW;
    logic [ADDR_WIDTH-1:0]           out_MemoryAddress;
    logic [DATA_WIDTH-1:0]           out_MemoryWriteData;
    logic [DATA_WIDTH-1:0]           in_MemoryReadData;
    logic                            in_MemoryWait;

    // Arbiter side
    modport slave (
        input  in_PortRequest, in_PortRW, in_PortAddress, in_PortWriteData,
        input  in_MemoryReadData, in_MemoryWait,
        output out_PortWait, out_PortReadData,
        output out_MemoryRequest, out_MemoryRW, out_MemoryAddress, out_MemoryWriteData
    );

    // Caches and memory side
    modport master (
        output in_PortRequest, in_PortRW, in_PortAddress, in_PortWriteData,
        output in_MemoryReadData, in_MemoryWait,
        input  out_PortWait, out_PortReadData,
        input  out_MemoryRequest, out_MemoryRW, out_MemoryAddress, out_MemoryWriteData
    );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: lowest index in fixed mode, first requester after `last` in round-robin mode.
module rr_priority_picker
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   last,
    input  logic                      mode,
    output logic [idx_width(N)-1:0]   winner,
    output logic                      valid
);
    localparam int unsigned IDX_W = idx_width(N);

    // Scan from the far end so the nearest candidate is the last one assigned.
    always_comb begin
        winner = '0;
        valid  = |req;
        if (mode == PRIO_FIXED) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winner = IDX_W'(i);
                end
            end
        end else begin
            for (int k = int'(N); k >= 1; k--) begin
                if (req[IDX_W'((int'(last) + k) % int'(N))]) begin
                    winner = IDX_W'((int'(last) + k) % int'(N));
                end
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory bus among NUM_PORTS cache requesters with an IDLE/BUSY/DONE handshake.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input logic             clock,
    input logic             reset,
    memory_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(NUM_PORTS);
    localparam logic        MODE  = (PRIORITY_MODE == 1) ? PRIO_RR : PRIO_FIXED;

    state_e                  state_q, state_d;
    logic                    load_c, capture_c;
    logic [IDX_W-1:0]        winner_c;
    logic                    winner_valid_c;
    logic [IDX_W-1:0]        grant_q, last_q;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic [NUM_PORTS-1:0]    port_wait_c;

    rr_priority_picker #(.N(NUM_PORTS)) u_picker (
        .req    (bus.in_PortRequest),
        .last   (last_q),
        .mode   (MODE),
        .winner (winner_c),
        .valid  (winner_valid_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration happens only in IDLE; a finished access always spends one cycle in DONE.
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_valid_c) begin
                    state_d = BUSY;
                    load_c  = 1'b1;
                end
            end
            BUSY: begin
                if (!bus.in_MemoryWait) begin
                    state_d   = DONE;
                    capture_c = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner's request is latched so memory outputs never depend on live port inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (load_c) begin
                grant_q <= winner_c;
                last_q  <= winner_c;
                rw_q    <= bus.in_PortRW[winner_c];
                addr_q  <= bus.in_PortAddress[int'(winner_c)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= bus.in_PortWriteData[int'(winner_c)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (capture_c) begin
                rdata_q <= bus.in_MemoryReadData;
            end
        end
    end

    always_comb begin
        port_wait_c = '1;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (state_q == DONE && grant_q == IDX_W'(i)) begin
                port_wait_c[i] = 1'b0;
            end
        end
    end

    assign bus.out_PortWait        = port_wait_c;
    assign bus.out_PortReadData    = rdata_q;
    assign bus.out_MemoryRequest   = (state_q == BUSY);
    assign bus.out_MemoryRW        = rw_q;
    assign bus.out_MemoryAddress   = addr_q;
    assign bus.out_MemoryWriteData = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter and a 4-port round-robin arbiter driven cycle by cycle.
module tb_memory_arbiter;

    logic clock;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    memory_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) f ();
    memory_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) r ();

    memory_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut_fix (
        .clock (clock),
        .reset (reset),
        .bus   (f.slave)
    );

    memory_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut_rr (
        .clock (clock),
        .reset (reset),
        .bus   (r.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] rr_addr [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
    logic [31:0] rr_wait [5] = '{32'hE, 32'hD, 32'hB, 32'h7, 32'hE};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        reset                = 1'b0;
        f.in_PortRequest     = '0;
        f.in_PortRW          = '0;
        f.in_PortAddress     = '0;
        f.in_PortWriteData   = '0;
        f.in_MemoryReadData  = '0;
        f.in_MemoryWait      = 1'b1;
        r.in_PortRequest     = '0;
        r.in_PortRW          = '0;
        r.in_PortAddress     = '0;
        r.in_PortWriteData   = '0;
        r.in_MemoryReadData  = '0;
        r.in_MemoryWait      = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_wait",  32'(f.out_PortWait), 32'h3);
        chk("rst_req",   32'(f.out_MemoryRequest), 32'h0);
        chk("rst_rw",    32'(f.out_MemoryRW), 32'h0);
        chk("rst_addr",  f.out_MemoryAddress, 32'h0);
        chk("rst_wdata", f.out_MemoryWriteData, 32'h0);
        chk("rst_rdata", f.out_PortReadData, 32'h0);
        chk("rst_rr_wait", 32'(r.out_PortWait), 32'hF);
        reset = 1'b1;
        step();

        // Single read from port 1, zero-wait memory
        f.in_MemoryWait     = 1'b0;
        f.in_MemoryReadData = 32'hDEADBEEF;
        f.in_PortRequest    = 2'b10;
        f.in_PortRW         = 2'b00;
        f.in_PortAddress    = {32'h100, 32'h0};
        step();
        chk("rd_busy_req",  32'(f.out_MemoryRequest), 32'h1);
        chk("rd_busy_addr", f.out_MemoryAddress, 32'h100);
        chk("rd_busy_rw",   32'(f.out_MemoryRW), 32'h0);
        chk("rd_busy_wait", 32'(f.out_PortWait), 32'h3);
        step();
        chk("rd_done_req",  32'(f.out_MemoryRequest), 32'h0);
        chk("rd_done_wait", 32'(f.out_PortWait), 32'h1);
        chk("rd_done_data", f.out_PortReadData, 32'hDEADBEEF);
        f.in_PortRequest = 2'b00;
        step();
        chk("rd_idle_wait", 32'(f.out_PortWait), 32'h3);
        chk("rd_idle_req",  32'(f.out_MemoryRequest), 32'h0);

        // Write from port 0 with three memory wait cycles
        f.in_MemoryWait    = 1'b1;
        f.in_PortRequest   = 2'b01;
        f.in_PortRW        = 2'b01;
        f.in_PortAddress   = {32'h0, 32'h40};
        f.in_PortWriteData = {32'h0, 32'h55AA};
        step();
        for (int k = 0; k < 4; k++) begin
            chk("wr_busy_req",   32'(f.out_MemoryRequest), 32'h1);
            chk("wr_busy_rw",    32'(f.out_MemoryRW), 32'h1);
            chk("wr_busy_wdata", f.out_MemoryWriteData, 32'h55AA);
            chk("wr_busy_addr",  f.out_MemoryAddress, 32'h40);
            chk("wr_busy_wait",  32'(f.out_PortWait), 32'h3);
            if (k == 3) f.in_MemoryWait = 1'b0;
            step();
        end
        chk("wr_done_wait", 32'(f.out_PortWait), 32'h2);
        f.in_PortRequest = 2'b00;
        f.in_PortRW      = 2'b00;
        step();
        chk("wr_after_wait", 32'(f.out_PortWait), 32'h3);

        // Fixed priority: ports 0 and 1 together
        f.in_PortRequest    = 2'b11;
        f.in_PortAddress    = {32'h300, 32'h200};
        f.in_MemoryReadData = 32'h11111111;
        step();
        chk("fp_first_addr", f.out_MemoryAddress, 32'h200);
        chk("fp_first_wait", 32'(f.out_PortWait), 32'h3);
        step();
        chk("fp_first_done", 32'(f.out_PortWait), 32'h2);
        chk("fp_first_data", f.out_PortReadData, 32'h11111111);
        f.in_PortRequest    = 2'b10;
        f.in_MemoryReadData = 32'h22222222;
        step();
        chk("fp_gap_wait", 32'(f.out_PortWait), 32'h3);
        step();
        chk("fp_second_addr", f.out_MemoryAddress, 32'h300);
        chk("fp_second_wait", 32'(f.out_PortWait), 32'h3);
        step();
        chk("fp_second_done", 32'(f.out_PortWait), 32'h1);
        chk("fp_second_data", f.out_PortReadData, 32'h22222222);
        f.in_PortRequest = 2'b00;
        step();

        // Reset during a memory wait, with port 1 also pending
        f.in_MemoryWait  = 1'b1;
        f.in_PortRequest = 2'b11;
        f.in_PortAddress = {32'h90, 32'h80};
        step();
        chk("mr_busy_addr", f.out_MemoryAddress, 32'h80);
        step();
        chk("mr_still_busy", 32'(f.out_MemoryRequest), 32'h1);
        reset = 1'b0;
        #1;
        chk("mr_rst_req",  32'(f.out_MemoryRequest), 32'h0);
        chk("mr_rst_wait", 32'(f.out_PortWait), 32'h3);
        chk("mr_rst_addr", f.out_MemoryAddress, 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("mr_reissue_req",  32'(f.out_MemoryRequest), 32'h1);
        chk("mr_reissue_addr", f.out_MemoryAddress, 32'h80);
        f.in_MemoryWait = 1'b0;
        step();
        chk("mr_done_wait", 32'(f.out_PortWait), 32'h2);
        f.in_PortRequest = 2'b00;
        step();

        // Back-to-back: port 0 keeps requesting after completion
        f.in_PortRequest = 2'b01;
        f.in_PortAddress = {32'h0, 32'h10};
        step();
        chk("bb_busy1", 32'(f.out_MemoryRequest), 32'h1);
        step();
        chk("bb_done1", 32'(f.out_PortWait), 32'h2);
        step();
        chk("bb_idle_wait", 32'(f.out_PortWait), 32'h3);
        chk("bb_idle_req",  32'(f.out_MemoryRequest), 32'h0);
        step();
        chk("bb_busy2", 32'(f.out_MemoryRequest), 32'h1);
        chk("bb_busy2_wait", 32'(f.out_PortWait), 32'h3);
        f.in_PortRequest = 2'b00;
        step();
        chk("bb_done2", 32'(f.out_PortWait), 32'h2);
        step();
        chk("bb_no_dup", 32'(f.out_PortWait), 32'h3);
        step();
        chk("bb_stay_idle", 32'(f.out_MemoryRequest), 32'h0);

        // Round-robin: four ports requesting continuously
        r.in_MemoryWait  = 1'b0;
        r.in_PortAddress = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        r.in_PortRequest = 4'hF;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_busy_addr", r.out_MemoryAddress, rr_addr[g]);
            chk("rr_busy_wait", 32'(r.out_PortWait), 32'hF);
            step();
            chk("rr_done_wait", 32'(r.out_PortWait), rr_wait[g]);
            step();
            chk("rr_idle_req", 32'(r.out_MemoryRequest), 32'h0);
        end
        r.in_PortRequest = 4'h0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
